// File: rtl/nibble_serial_adder16_pkg.sv
// Shared widths, slice geometry and FSM state type for the nibble-serial 16-bit adder.
package nibble_serial_adder16_pkg;

  localparam int unsigned N       = 16;
  localparam int unsigned SLICE   = 4;
  localparam int unsigned NSLICES = N / SLICE;
  localparam int unsigned IdxW    = $clog2(NSLICES);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/nibble_serial_adder16_if.sv
// Request/result bundle between the ALU (master) and the serial adder (slave).
interface nibble_serial_adder16_if;
  import nibble_serial_adder16_pkg::*;

  logic         start;
  logic [N-1:0] inp1;
  logic [N-1:0] inp2;
  logic         cin;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, inp1, inp2, cin,
    input  sum, co, ovf, busy, done
  );

  modport slave (
    input  start, inp1, inp2, cin,
    output sum, co, ovf, busy, done
  );

endinterface

// File: rtl/nibble_serial_adder16_add4.sv
// Combinational 4-bit ripple adder built from full-adder bit cells; exposes the MSB carry-in.
module nibble_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       co_o
);

  logic [4:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c3_o = c[3];
  assign co_o = c[4];

endmodule

// File: rtl/nibble_serial_adder16.sv
// 16-bit adder computing one nibble per cycle, LSB first, through a single 4-bit slice.
module nibble_serial_adder16
  import nibble_serial_adder16_pkg::*;
(
  input  logic clk,
  input  logic rst,
  nibble_serial_adder16_if.slave bus
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [N-1:0]      op_a_q, op_a_d;
  logic [N-1:0]      op_b_q, op_b_d;
  logic [N-1:0]      sum_q, sum_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  slice_a, slice_b, slice_s;
  logic              slice_c3, slice_co;

  assign slice_a = op_a_q[int'(idx_q) * SLICE +: SLICE];
  assign slice_b = op_b_q[int'(idx_q) * SLICE +: SLICE];

  nibble_add4 u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .c3_o (slice_c3),
    .co_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      // DONE accepts a new request exactly like IDLE for back-to-back issue.
      StIdle, StDone: begin
        if (bus.start) begin
          op_a_d  = bus.inp1;
          op_b_d  = bus.inp2;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[int'(idx_q) * SLICE +: SLICE] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NSLICES - 1)) begin
          co_d    = slice_co;
          ovf_d   = slice_c3 ^ slice_co;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Directed bench for the nibble-serial adder: reset, carries, overflow, handshake, mid-run reset.
module tb_nibble_serial_adder16;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  nibble_serial_adder16_if bus ();

  nibble_serial_adder16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue from the current cycle, then follow the run to the DONE cycle and check it.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic eco, input logic eovf,
                        input string tag);
    int n = 0;
    int busy_cnt = 0;
    bus.start = 1'b1;
    bus.inp1  = a;
    bus.inp2  = b;
    bus.cin   = c;
    step();
    bus.start = 1'b0;
    bus.inp1  = 16'hDEAD;
    bus.inp2  = 16'hBEEF;
    bus.cin   = 1'b1;
    check({tag, " sum cleared"}, bus.sum, 16'h0000);
    check({tag, " co cleared"}, bus.co, 1'b0);
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      step();
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " busy cycles"}, busy_cnt, 4);
    check({tag, " sum"}, bus.sum, es);
    check({tag, " co"}, bus.co, eco);
    check({tag, " ovf"}, bus.ovf, eovf);
    check({tag, " busy in done"}, bus.busy, 1'b0);
  endtask

  task automatic idle_after(input logic [15:0] es, input string tag);
    step();
    check({tag, " done drops"}, bus.done, 1'b0);
    check({tag, " idle busy"}, bus.busy, 1'b0);
    check({tag, " sum held"}, bus.sum, es);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.inp1  = 16'h0000;
    bus.inp2  = 16'h0000;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    step();
    step();
    check("reset sum", bus.sum, 16'h0000);
    check("reset co", bus.co, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    rst = 1'b0;
    step();

    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    idle_after(16'h5555, "basic");

    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    idle_after(16'h0000, "ripple");
    do_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple cin");
    idle_after(16'h0000, "ripple cin");

    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf pos");
    idle_after(16'h8000, "ovf pos");
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf neg");
    idle_after(16'h0000, "ovf neg");

    // Start held high with fresh operands through RUN must not disturb the op in flight.
    bus.start = 1'b1;
    bus.inp1  = 16'h1234;
    bus.inp2  = 16'h4321;
    bus.cin   = 1'b0;
    step();
    bus.inp1 = 16'hAAAA;
    bus.inp2 = 16'h1111;
    bus.cin  = 1'b1;
    step();
    step();
    step();
    bus.start = 1'b0;
    step();
    check("hold done", bus.done, 1'b1);
    check("hold sum", bus.sum, 16'h5555);
    idle_after(16'h5555, "hold");

    do_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, "b2b first");
    do_add(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "b2b second");
    idle_after(16'h0003, "b2b");

    // Reset in the second RUN cycle, after the low nibble has landed.
    bus.start = 1'b1;
    bus.inp1  = 16'h1234;
    bus.inp2  = 16'h4321;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    check("midrun partial", bus.sum, 16'h0005);
    check("midrun busy", bus.busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort sum", bus.sum, 16'h0000);
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    check("abort co", bus.co, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus.done) seen++;
        step();
      end
      check("abort no done", seen, 0);
    end
    do_add(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, "after abort");
    idle_after(16'h0100, "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
